lif_neuron_scheduler: RTL and testbench
=======================================

LIF_NEURON_SCHEDULER -- requirements
Module: lif_neuron_scheduler

Interface
REQ-001 Parameter MAX_COUNT, default 24'd10_000_000: tick compare value used when period==0.
REQ-002 Parameter LEAK_SHIFT, default 1: membrane leak is v>>LEAK_SHIFT per tick.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 period  input  8  tick period select; 0 selects MAX_COUNT, else compare={6'b0,period,10'b0}.
REQ-006 threshold  input  8  spike threshold; 0 disables spiking.
REQ-007 stim_valid  input  1  stimulus request.
REQ-008 stim_idx  input  2  target neuron 0..3.
REQ-009 stim_weight  input  8  unsigned current to inject.
REQ-010 stim_ready  output  1  high when a stimulus is accepted this cycle if valid.
REQ-011 spike  output  4  one-cycle spike pulse per neuron.
REQ-012 mem_sel  input  2  neuron whose membrane is shown on mem_out.
REQ-013 mem_out  output  8  registered membrane of neuron mem_sel, 1-cycle latency.
REQ-014 busy  output  1  high while in UPDATE.
REQ-015 overrun  output  1  sticky flag: a tick was dropped.

Function
REQ-016 24-bit prescaler counts up each cycle; when counter>=compare it SHALL load 0 and assert internal tick for that cycle, giving a tick every compare+1 cycles.
REQ-017 A period change mid-count SHALL take effect immediately; if counter already >= new compare, tick fires on the next cycle.
REQ-018 State per neuron i: membrane v[i] 8-bit, pending p[i] 8-bit.
REQ-019 FSM states IDLE and UPDATE; busy=1 only in UPDATE.
REQ-020 stim_ready SHALL equal (state==IDLE) and not reset.
REQ-021 Accepted stimulus (valid&ready): p[stim_idx] <= min(p[stim_idx]+stim_weight, 255).
REQ-022 IDLE + tick -> UPDATE with index 0 on the next cycle; stimulus accepted in the tick cycle SHALL be included in that update.
REQ-023 UPDATE processes one neuron per cycle, index 0,1,2,3, then returns to IDLE; exactly 4 cycles busy.
REQ-024 Update of neuron i: n = v[i] - (v[i]>>LEAK_SHIFT) + p[i], computed 9-bit, saturated to 255; p[i] <= 0.
REQ-025 If threshold!=0 and n>=threshold: v[i] <= 0 and spike[i] pulses high for that update cycle's following cycle (registered); else v[i] <= n.
REQ-026 spike bits are 0 except per REQ-025; at most one bit set per cycle.
REQ-027 Tick arriving while in UPDATE SHALL be dropped and set overrun=1; overrun cleared only by reset.
REQ-028 stim_valid in UPDATE is not accepted; requester holds stim_valid/idx/weight stable until ready.
REQ-029 mem_out <= v[mem_sel] each cycle, reflecting the value after any same-cycle update.

Reset
REQ-030 reset SHALL, on the next edge, clear counter, all v[i], all p[i], spike=0, mem_out=0, overrun=0, state=IDLE (busy=0); stim_ready=0 while reset is high.
REQ-031 Reset asserted mid-UPDATE aborts the sweep; no spike issued after the reset edge.

Verification
REQ-032 MAX_COUNT=15, period=0, reset released at cycle 0 -> tick every 16 cycles, busy high 4 cycles after each tick.
REQ-033 threshold=100, LEAK_SHIFT=1, inject 60 to neuron 2 before each of two ticks -> after tick 1 v[2]=60, after tick 2 v[2]=60-30+60=90, no spike; third 60 -> 45+60=105 -> spike[2] pulse, v[2]=0.
REQ-034 Inject 200 then 100 to neuron 0 in one period -> p[0]=255; update gives v[0]=255 (saturated), threshold=0 -> no spike.
REQ-035 Stimulus valid during busy -> stim_ready=0, accepted on first IDLE cycle; stimulus coincident with tick included in that sweep.
REQ-036 MAX_COUNT=2 -> tick during UPDATE, overrun=1 and stays set until reset.
REQ-037 reset asserted at UPDATE index 1 with neuron 3 due to spike -> no spike[3], all mem_out reads 0, busy=0.

Source files
------------

// File: rtl/lif_neuron_scheduler.sv
// lif_neuron_scheduler: four leaky integrate-and-fire neurons, swept one per cycle on each prescaler tick
module lif_neuron_scheduler #(
    parameter logic [23:0] MAX_COUNT = 24'd10_000_000,
    parameter int LEAK_SHIFT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] period,
    input  logic [7:0] threshold,
    input  logic       stim_valid,
    input  logic [1:0] stim_idx,
    input  logic [7:0] stim_weight,
    output logic       stim_ready,
    output logic [3:0] spike,
    input  logic [1:0] mem_sel,
    output logic [7:0] mem_out,
    output logic       busy,
    output logic       overrun
);
    typedef enum logic {IDLE, UPDATE} state_t;
    state_t state, state_n;
    logic [23:0] count, compare;
    logic [1:0] idx, idx_n;
    logic [7:0] v [4];
    logic [7:0] v_n [4];
    logic [7:0] p [4];
    logic [7:0] p_n [4];
    logic [3:0] spike_n;
    logic [8:0] n, sum;
    logic [7:0] n_sat;
    logic tick, accept, fire;

    assign compare = period == 8'd0 ? MAX_COUNT : {6'b0, period, 10'b0};
    assign tick = count >= compare;
    assign stim_ready = state == IDLE && !reset;
    assign busy = state == UPDATE;
    assign accept = stim_valid && stim_ready;
    assign sum = {1'b0, p[stim_idx]} + {1'b0, stim_weight};
    // leak term cannot exceed v, so the 9-bit sum never wraps
    assign n = {1'b0, v[idx]} - ({1'b0, v[idx]} >> LEAK_SHIFT) + {1'b0, p[idx]};
    assign n_sat = n[8] ? 8'hff : n[7:0];
    assign fire = threshold != 8'd0 && n_sat >= threshold;

    always_comb begin
        state_n = state;
        idx_n = idx;
        v_n = v;
        p_n = p;
        spike_n = '0;
        if (state == IDLE) begin
            if (accept) p_n[stim_idx] = sum[8] ? 8'hff : sum[7:0];
            if (tick) begin
                state_n = UPDATE;
                idx_n = '0;
            end
        end else begin
            v_n[idx] = fire ? 8'd0 : n_sat;
            p_n[idx] = '0;
            spike_n[idx] = fire;
            idx_n = idx + 2'd1;
            if (idx == 2'd3) state_n = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            state <= IDLE;
            idx <= '0;
            v <= '{default: '0};
            p <= '{default: '0};
            spike <= '0;
            mem_out <= '0;
            overrun <= 1'b0;
        end else begin
            count <= tick ? '0 : count + 24'd1;
            state <= state_n;
            idx <= idx_n;
            v <= v_n;
            p <= p_n;
            spike <= spike_n;
            mem_out <= v_n[mem_sel];
            if (tick && state == UPDATE) overrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_lif_neuron_scheduler.sv
// tb_lif_neuron_scheduler: random stimulus against a cycle-level behavioural model plus directed scenarios
module tb_lif_neuron_scheduler;
    localparam logic [23:0] MAXC = 24'd15;
    logic clk = 0, reset = 1;
    logic [7:0] period = 0, threshold = 0, stim_weight = 0;
    logic stim_valid = 0;
    logic [1:0] stim_idx = 0, mem_sel = 0;
    logic stim_ready, busy, overrun;
    logic [3:0] spike;
    logic [7:0] mem_out;
    logic f_ready, f_busy, f_over;
    logic [3:0] f_spike;
    logic [7:0] f_mem;
    int n_cmp = 0, n_fail = 0;
    int m_cnt = 0, m_pos = -1, m_mem = 0;
    int mv [4];
    int mp [4];
    logic [3:0] m_spike = 0;
    bit m_over = 0, m_init = 0, m_acc = 0, saw2 = 0, saw3 = 0;

    always #5 clk = ~clk;

    lif_neuron_scheduler #(.MAX_COUNT(MAXC), .LEAK_SHIFT(1)) dut (
        .clk(clk), .reset(reset), .period(period), .threshold(threshold),
        .stim_valid(stim_valid), .stim_idx(stim_idx), .stim_weight(stim_weight),
        .stim_ready(stim_ready), .spike(spike), .mem_sel(mem_sel), .mem_out(mem_out),
        .busy(busy), .overrun(overrun)
    );

    lif_neuron_scheduler #(.MAX_COUNT(24'd2), .LEAK_SHIFT(1)) u_fast (
        .clk(clk), .reset(reset), .period(8'd0), .threshold(8'd0),
        .stim_valid(1'b0), .stim_idx(2'd0), .stim_weight(8'd0),
        .stim_ready(f_ready), .spike(f_spike), .mem_sel(2'd0), .mem_out(f_mem),
        .busy(f_busy), .overrun(f_over)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: tick when the count has reached the compare value,
    // sweep neurons 0..3 one per cycle, leak halves the membrane.
    always @(posedge clk) begin
        int cmp, nv, nxt;
        bit tk;
        if (reset) begin
            m_init = 1; m_cnt = 0; m_pos = -1; m_spike = 0; m_mem = 0; m_over = 0; m_acc = 0;
            for (int i = 0; i < 4; i++) begin mv[i] = 0; mp[i] = 0; end
        end else begin
            cmp = (period == 0) ? int'(MAXC) : int'(period) * 1024;
            tk = m_cnt >= cmp;
            m_cnt = tk ? 0 : m_cnt + 1;
            m_spike = 0;
            m_acc = 0;
            nxt = m_pos;
            if (m_pos < 0) begin
                if (stim_valid) begin
                    m_acc = 1;
                    mp[stim_idx] = (mp[stim_idx] + stim_weight > 255) ? 255 : mp[stim_idx] + stim_weight;
                end
                if (tk) nxt = 0;
            end else begin
                nv = mv[m_pos] - mv[m_pos] / 2 + mp[m_pos];
                if (nv > 255) nv = 255;
                mp[m_pos] = 0;
                if (threshold != 0 && nv >= threshold) begin
                    mv[m_pos] = 0;
                    m_spike[m_pos] = 1'b1;
                end else mv[m_pos] = nv;
                if (tk) m_over = 1;
                nxt = (m_pos == 3) ? -1 : m_pos + 1;
            end
            m_pos = nxt;
            m_mem = mv[mem_sel];
        end
    end

    always @(negedge clk) begin
        if (m_init) begin
            chk("spike", spike, m_spike);
            chk("mem_out", mem_out, m_mem);
            chk("busy", busy, m_pos >= 0);
            chk("overrun", overrun, m_over);
            chk("stim_ready", stim_ready, m_pos < 0 && !reset);
            if (spike[2]) saw2 = 1;
            if (spike[3]) saw3 = 1;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset;
        reset = 1;
        #1 chk("ready_in_reset", stim_ready, 0);
        step(1);
        reset = 0;
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: got timeout expected completion", name);
    endtask

    task automatic inject(input logic [1:0] i, input logic [7:0] w);
        int k = 0;
        stim_valid = 1; stim_idx = i; stim_weight = w;
        do begin step(1); k++; end while (!m_acc && k < 50);
        stim_valid = 0;
        if (!m_acc) timeout("inject");
    endtask

    task automatic run_sweep(input string name);
        int k = 0;
        while (m_pos < 0 && k < 200) begin step(1); k++; end
        while (m_pos >= 0 && k < 200) begin step(1); k++; end
        if (k >= 200) timeout(name);
    endtask

    initial begin
        int k;
        step(1);
        do_reset;
        chk("fast_over_reset", f_over, 0);
        // tick cadence: first busy 16 cycles after reset, busy 4, idle 12
        k = 0; while (!busy && k < 40) begin step(1); k++; end
        chk("first_busy", k, 16);
        k = 0; while (busy && k < 40) begin step(1); k++; end
        chk("busy_len", k, 4);
        k = 0; while (!busy && k < 40) begin step(1); k++; end
        chk("idle_len", k, 12);
        chk("fast_overrun", f_over, 1);
        step(20);
        chk("fast_overrun_sticky", f_over, 1);
        // integrate 60 three times at threshold 100
        do_reset;
        chk("fast_over_cleared", f_over, 0);
        threshold = 100; mem_sel = 2; saw2 = 0;
        inject(2, 60); run_sweep("s1");
        chk("v2_after_1", mem_out, 60);
        inject(2, 60); run_sweep("s2");
        chk("v2_after_2", mem_out, 90);
        chk("no_spike_yet", saw2, 0);
        inject(2, 60); run_sweep("s3");
        chk("v2_after_spike", mem_out, 0);
        chk("spike2_seen", saw2, 1);
        // pending saturation with spiking disabled
        do_reset;
        threshold = 0; mem_sel = 0;
        inject(0, 200); inject(0, 100); run_sweep("sat");
        chk("v0_saturated", mem_out, 255);
        // stimulus during busy waits for the first idle cycle
        k = 0; while (m_pos < 0 && k < 40) begin step(1); k++; end
        stim_valid = 1; stim_idx = 1; stim_weight = 7;
        #1 chk("ready_while_busy", stim_ready, 0);
        k = 0; do begin step(1); k++; end while (!m_acc && k < 20);
        stim_valid = 0;
        chk("accept_delay", k, 5);
        // stimulus in the tick cycle joins that sweep
        do_reset;
        threshold = 0; mem_sel = 1;
        k = 0; while (m_cnt != 15 && k < 40) begin step(1); k++; end
        stim_valid = 1; stim_idx = 1; stim_weight = 40;
        step(1);
        stim_valid = 0;
        chk("busy_after_tick", busy, 1);
        run_sweep("coinc");
        chk("v1_coincident", mem_out, 40);
        run_sweep("leak");
        chk("v1_leaked", mem_out, 20);
        // reset mid-sweep suppresses the pending spike of neuron 3
        do_reset;
        threshold = 10;
        inject(3, 50);
        k = 0; while (m_pos != 1 && k < 40) begin step(1); k++; end
        saw3 = 0;
        reset = 1;
        step(1);
        chk("busy_after_abort", busy, 0);
        chk("spike_after_abort", spike, 0);
        reset = 0;
        for (int s = 0; s < 4; s++) begin
            mem_sel = 2'(s);
            step(1);
            chk("mem_zero_after_abort", mem_out, 0);
        end
        step(8);
        chk("no_spike3", saw3, 0);
        // randomized run against the model
        threshold = 120;
        for (int c = 0; c < 4000; c++) begin
            if (!stim_valid || m_acc) begin
                stim_valid = ($urandom_range(0, 2) == 0);
                stim_idx = 2'($urandom_range(0, 3));
                stim_weight = 8'($urandom_range(0, 255));
            end
            if ($urandom_range(0, 199) == 0) begin
                if ($urandom_range(0, 3) == 0) threshold = 0;
                else threshold = 8'($urandom_range(1, 255));
            end
            if (period == 0 && $urandom_range(0, 499) == 0) period = 1;
            else if (period != 0 && $urandom_range(0, 149) == 0) period = 0;
            mem_sel = 2'($urandom_range(0, 3));
            reset = ($urandom_range(0, 399) == 0);
            step(1);
        end
        reset = 0;
        stim_valid = 0;
        step(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
